rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-port arbiter and scoreboard for the RV32IM integer register file. The register file has one synchronous write port, shared by the in-order writeback (WB) stage and the multi-cycle divide unit, whose results return out of band. This block grants that port one requester per cycle and tracks destination registers with a divide in flight. It raises a decode-stage hazard so dependent instructions wait until the divide result is written.

## Interface
- MAX_DEFER, default 3: maximum consecutive cycles a pending divide result may lose arbitration before it takes priority over WB.

Ports. Reset rst is synchronous, active-high; clock is clk.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- wb_valid  in  1  WB stage write request.
- wb_rd  in  5  WB destination register.
- wb_data  in  32  WB write data.
- wb_stall  out  1  WB request not granted this cycle; pipeline holds WB.
- div_issue  in  1  divide issued this cycle; marks div_issue_rd busy.
- div_issue_rd  in  5  destination of the issued divide.
- div_valid  in  1  divide result available; held until div_ready.
- div_rd  in  5  divide result destination.
- div_data  in  32  divide result data.
- div_ready  out  1  divide result granted this cycle.
- id_rs1, id_rs2, id_rd  in  5 each  decode-stage source and destination indices.
- id_hazard  out  1  a decode index is busy; decode must stall.
- rf_we  out  1  register file write enable.
- rf_waddr  out  5  register file write address.
- rf_wd  out  32  register file write data.

## Operation
- State:
  - busy[31:1] scoreboard. busy[0] is hard-wired 0.
  - defer_cnt, clog2(MAX_DEFER+1) bits, saturating.
- Arbitration (combinational, from current inputs and defer_cnt):
  - Only wb_valid: grant WB.
  - Only div_valid: grant divide.
  - Both valid, defer_cnt < MAX_DEFER: grant WB.
  - Both valid, defer_cnt == MAX_DEFER: grant divide.
  - Neither valid: no grant; rf_we=0.
- Outputs:
  - wb_stall = wb_valid & ~grant_wb.
  - div_ready = div_valid & grant_div.
  - rf_waddr and rf_wd are muxed from the granted source. With no grant they are 0.
  - rf_we = grant & (granted rd != 0). An x0 request is still granted and consumes the port, but performs no write.
- defer_cnt:
  - Increments, saturating at MAX_DEFER, when div_valid & ~grant_div.
  - Clears to 0 when div_valid is low or the divide is granted.
- Scoreboard:
  - Divide grant clears busy[div_rd].
  - div_issue with div_issue_rd != 0 sets busy[div_issue_rd].
  - If the same index is set and cleared in one cycle, set wins.
  - WB writes never modify busy.
- id_hazard = busy[id_rs1] | busy[id_rs2] | busy[id_rd], read from registered busy. A bit cleared at edge N drops the hazard in cycle N+1, when the register file already holds the new value. No bypass is provided.
- WB writes to a busy rd are prevented by id_hazard. If one occurs anyway, it is written normally and busy is unchanged.

## Timing
- Request to write: 0 cycles of added latency. The grant and rf_* outputs are combinational, and the register file captures on the same posedge.
- During rst and in the cycle after deassertion: busy=0, defer_cnt=0.
- Output values while rst is high: rf_we=0, rf_waddr=0, rf_wd=0, wb_stall=0, div_ready=0, id_hazard=0. Grants are suppressed regardless of inputs.
- Reset mid-operation discards all outstanding busy bits and any pending divide result. The divide unit is reset by the same rst.
- Worst-case divide wait under continuous WB traffic: MAX_DEFER+1 cycles from div_valid to div_ready.
- Worst-case WB stall per divide result: 1 cycle.
- div_valid, div_rd and div_data must stay stable until div_ready. The arbiter does not buffer them.

## Test plan
- Reset: drive wb_valid=1 and div_valid=1 with rst=1 -> rf_we=0, wb_stall=0, div_ready=0, id_hazard=0. After release, busy reads all zero.
- Scoreboard round trip:
  - div_issue rd=5 at cycle 0. Then id_rs1=5 -> id_hazard=1 from cycle 1.
  - div_valid rd=5, data=0xDEADBEEF at cycle 4, with WB idle -> div_ready=1, rf_we=1, rf_waddr=5, rf_wd=0xDEADBEEF.
  - id_hazard=0 at cycle 5.
- Starvation bound: MAX_DEFER=3, wb_valid held high every cycle, div_valid high from cycle 0 -> WB granted cycles 0-2 (wb_stall=0), divide granted cycle 3 (div_ready=1, wb_stall=1), WB granted again cycle 4.
- x0 handling:
  - div_issue rd=0 -> busy unchanged, id_hazard=0 for id_rs1=0.
  - WB rd=0 -> wb_stall=0, rf_we=0.
- Set/clear collision: divide grant for rd=7 in the same cycle as div_issue rd=7 -> busy[7]=1 next cycle, so id_rs2=7 gives id_hazard=1.
- Reset mid-operation: busy[3] and busy[9] set, rst pulsed one cycle -> id_hazard=0 for indices 3 and 9, defer_cnt=0. A subsequent WB-only request is granted with no stall.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Write-port arbiter and in-flight-divide scoreboard for the RV32IM integer
//   register file. The single synchronous write port is shared by the in-order
//   writeback stage and the out-of-band divide unit. WB normally wins. A divide
//   result that has lost MAX_DEFER consecutive cycles takes the port on the next
//   cycle. Destinations of issued divides are marked busy, which raises a decode
//   hazard until the result is written.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   wb_valid/rd/data         WB write request;  wb_stall  = request not granted
//   div_issue/div_issue_rd   divide issued this cycle, marks its rd busy
//   div_valid/rd/data        divide result (held stable); div_ready = granted
//   id_rs1/rs2/rd            decode indices;    id_hazard = any index busy
//   rf_we/waddr/wd           register file write port (combinational, same edge)
module rf_wb_arbiter #(
  parameter int MAX_DEFER = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        wb_stall,
  input  logic        div_issue,
  input  logic [4:0]  div_issue_rd,
  input  logic        div_valid,
  input  logic [4:0]  div_rd,
  input  logic [31:0] div_data,
  output logic        div_ready,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  output logic        id_hazard,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wd
);

  // A zero MAX_DEFER still needs a 1-bit counter to keep the types legal.
  localparam int DW = (MAX_DEFER > 0) ? $clog2(MAX_DEFER + 1) : 1;
  localparam logic [DW-1:0] DEFER_MAX = DW'(MAX_DEFER);

  logic [DW-1:0] defer_q, defer_d;
  // Bit 0 is kept in the vector for direct indexing but is never set.
  logic [31:0]   busy_q, busy_d;

  logic          grant_wb, grant_div, div_prio;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign div_prio  = (defer_q == DEFER_MAX);
  // Divide wins when alone, or when it has been deferred long enough.
  assign grant_div = ~rst & div_valid & (~wb_valid | div_prio);
  assign grant_wb  = ~rst & wb_valid & ~grant_div;

  assign wb_stall  = ~rst & wb_valid & ~grant_wb;
  assign div_ready = grant_div;

  always_comb begin
    rf_waddr = 5'd0;
    rf_wd    = 32'd0;
    if (grant_div) begin
      rf_waddr = div_rd;
      rf_wd    = div_data;
    end else if (grant_wb) begin
      rf_waddr = wb_rd;
      rf_wd    = wb_data;
    end
  end

  // An x0 request still consumes the port but must not write.
  assign rf_we = (grant_div | grant_wb) & (rf_waddr != 5'd0);

  // ---------------------------------------------------------------------------
  // Deferral counter: counts consecutive lost cycles of a pending divide.
  // ---------------------------------------------------------------------------
  always_comb begin
    defer_d = '0;
    if (div_valid && !grant_div)
      defer_d = div_prio ? defer_q : defer_q + DW'(1);
  end

  // ---------------------------------------------------------------------------
  // Scoreboard. Set is applied after clear so an issue to the same rd as the
  // returning divide leaves the register busy for the new divide.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    if (grant_div)
      busy_d[div_rd] = 1'b0;
    if (div_issue && (div_issue_rd != 5'd0))
      busy_d[div_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Read from registered state only: a cleared bit drops the hazard the cycle
  // after the write edge, when the register file already holds the value.
  assign id_hazard = ~rst & (busy_q[id_rs1] | busy_q[id_rs2] | busy_q[id_rd]);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      defer_q <= '0;
    end else begin
      busy_q  <= busy_d;
      defer_q <= defer_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed-vector bench for rf_wb_arbiter. The stimulus process drives one
// vector per cycle and queues the hand-computed outputs for that cycle; the
// monitor pops and compares on the falling edge.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        wb_stall;
  logic        div_issue = 1'b0;
  logic [4:0]  div_issue_rd = '0;
  logic        div_valid = 1'b0;
  logic [4:0]  div_rd = '0;
  logic [31:0] div_data = '0;
  logic        div_ready;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_hazard;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wd;

  int total = 0;
  int bad   = 0;

  rf_wb_arbiter #(.MAX_DEFER(3)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_stall(wb_stall),
    .div_issue(div_issue), .div_issue_rd(div_issue_rd),
    .div_valid(div_valid), .div_rd(div_rd), .div_data(div_data), .div_ready(div_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_hazard(id_hazard),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        stall, dr, haz, we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } exp_t;

  exp_t q[$];

  task automatic cmp(string nm, string f, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%0h want=%0h", nm, f, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp(e.nm, "wb_stall",  32'(wb_stall),  32'(e.stall));
      cmp(e.nm, "div_ready", 32'(div_ready), 32'(e.dr));
      cmp(e.nm, "id_hazard", 32'(id_hazard), 32'(e.haz));
      cmp(e.nm, "rf_we",     32'(rf_we),     32'(e.we));
      cmp(e.nm, "rf_waddr",  32'(rf_waddr),  32'(e.wa));
      cmp(e.nm, "rf_wd",     rf_wd,          e.wd);
    end
  end

  // One vector: inputs for this cycle followed by the expected outputs.
  task automatic cyc(string nm, logic r,
                     logic wv, logic [4:0] wr, logic [31:0] wd,
                     logic dv, logic [4:0] dr, logic [31:0] dd,
                     logic iv, logic [4:0] ir,
                     logic [4:0] s1, logic [4:0] s2, logic [4:0] d,
                     logic e_st, logic e_dr, logic e_hz, logic e_we,
                     logic [4:0] e_wa, logic [31:0] e_wd);
    exp_t e;
    @(posedge clk); #1;
    rst = r;
    wb_valid = wv;  wb_rd = wr;  wb_data = wd;
    div_valid = dv; div_rd = dr; div_data = dd;
    div_issue = iv; div_issue_rd = ir;
    id_rs1 = s1; id_rs2 = s2; id_rd = d;
    e.nm = nm; e.stall = e_st; e.dr = e_dr; e.haz = e_hz; e.we = e_we;
    e.wa = e_wa; e.wd = e_wd;
    q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    //   name      rst wv wrd wdata          dv drd ddata          iv ird rs1 rs2 rd  st dr hz we wa  wd
    // Reset: requests and an issue held while rst is high are all suppressed.
    cyc("rst0",    1, 1, 1, 32'h1111_1111, 1, 2, 32'h2222_2222, 1, 4,  4, 1, 2,  0, 0, 0, 0, 0, 32'h0);
    cyc("rst1",    1, 1, 1, 32'h1111_1111, 1, 2, 32'h2222_2222, 1, 4,  4, 1, 2,  0, 0, 0, 0, 0, 32'h0);
    cyc("post0",   0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0,  4, 31, 2, 0, 0, 0, 0, 0, 32'h0);
    // Scoreboard round trip on x5.
    cyc("rt_iss",  0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 5,  5, 0, 0,  0, 0, 0, 0, 0, 32'h0);
    cyc("rt_c1",   0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0,  5, 0, 0,  0, 0, 1, 0, 0, 32'h0);
    cyc("rt_c2wb", 0, 1, 6, 32'h0000_0011, 0, 0, 32'h0,         0, 0,  5, 0, 0,  0, 0, 1, 1, 6, 32'h0000_0011);
    cyc("rt_c3",   0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0,  0, 0, 5,  0, 0, 1, 0, 0, 32'h0);
    cyc("rt_c4",   0, 0, 0, 32'h0,         1, 5, 32'hDEAD_BEEF, 0, 0,  5, 0, 0,  0, 1, 1, 1, 5, 32'hDEAD_BEEF);
    cyc("rt_c5",   0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0,  5, 5, 5,  0, 0, 0, 0, 0, 32'h0);
    // Starvation bound with continuous WB: three WB grants, then the divide.
    cyc("sv0",     0, 1, 10, 32'hA0,       1, 11, 32'hD0,       0, 0,  0, 0, 0,  0, 0, 0, 1, 10, 32'hA0);
    cyc("sv1",     0, 1, 12, 32'hA1,       1, 11, 32'hD0,       0, 0,  0, 0, 0,  0, 0, 0, 1, 12, 32'hA1);
    cyc("sv2",     0, 1, 13, 32'hA2,       1, 11, 32'hD0,       0, 0,  0, 0, 0,  0, 0, 0, 1, 13, 32'hA2);
    cyc("sv3",     0, 1, 13, 32'hA2,       1, 11, 32'hD0,       0, 0,  0, 0, 0,  1, 1, 0, 1, 11, 32'hD0);
    // Counter cleared by the grant: the next result again waits three cycles.
    cyc("sv4",     0, 1, 13, 32'hA2,       1, 14, 32'hD1,       0, 0,  0, 0, 0,  0, 0, 0, 1, 13, 32'hA2);
    cyc("sv5",     0, 1, 15, 32'hA3,       1, 14, 32'hD1,       0, 0,  0, 0, 0,  0, 0, 0, 1, 15, 32'hA3);
    cyc("sv6",     0, 1, 16, 32'hA4,       1, 14, 32'hD1,       0, 0,  0, 0, 0,  0, 0, 0, 1, 16, 32'hA4);
    cyc("sv7",     0, 1, 16, 32'hA4,       1, 14, 32'hD1,       0, 0,  0, 0, 0,  1, 1, 0, 1, 14, 32'hD1);
    cyc("sv8",     0, 1, 16, 32'hA4,       0, 0, 32'h0,         0, 0,  0, 0, 0,  0, 0, 0, 1, 16, 32'hA4);
    // x0: issue ignored, WB and divide to x0 granted without a write.
    cyc("x0_iss",  0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 0,  0, 0, 0,  0, 0, 0, 0, 0, 32'h0);
    cyc("x0_haz",  0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 32'h0);
    cyc("x0_wb",   0, 1, 0, 32'h55,        0, 0, 32'h0,         0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 32'h55);
    cyc("x0_div",  0, 0, 0, 32'h0,         1, 0, 32'h77,        0, 0,  0, 0, 0,  0, 1, 0, 0, 0, 32'h77);
    // Set/clear collision on x7: set wins.
    cyc("co_iss",  0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 7,  0, 7, 0,  0, 0, 0, 0, 0, 32'h0);
    cyc("co_both", 0, 0, 0, 32'h0,         1, 7, 32'h7777,      1, 7,  0, 7, 0,  0, 1, 1, 1, 7, 32'h7777);
    cyc("co_chk",  0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0,  0, 7, 0,  0, 0, 1, 0, 0, 32'h0);
    cyc("co_ret",  0, 0, 0, 32'h0,         1, 7, 32'h8,         0, 0,  0, 7, 0,  0, 1, 1, 1, 7, 32'h8);
    cyc("co_clr",  0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0,  0, 7, 0,  0, 0, 0, 0, 0, 32'h0);
    // Reset mid-operation with x3/x9 busy and defer count at 2.
    cyc("mr_i3",   0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 3,  3, 0, 0,  0, 0, 0, 0, 0, 32'h0);
    cyc("mr_i9",   0, 1, 21, 32'hB0,       1, 20, 32'hC0,       1, 9,  3, 0, 0,  0, 0, 1, 1, 21, 32'hB0);
    cyc("mr_d1",   0, 1, 22, 32'hB1,       1, 20, 32'hC0,       0, 0,  9, 0, 0,  0, 0, 1, 1, 22, 32'hB1);
    cyc("mr_rst",  1, 1, 22, 32'hB1,       1, 20, 32'hC0,       0, 0,  3, 9, 0,  0, 0, 0, 0, 0, 32'h0);
    cyc("mr_wb",   0, 1, 2, 32'h99,        0, 0, 32'h0,         0, 0,  3, 9, 0,  0, 0, 0, 1, 2, 32'h99);
    cyc("mr_s0",   0, 1, 23, 32'hB2,       1, 24, 32'hC1,       0, 0,  3, 9, 9,  0, 0, 0, 1, 23, 32'hB2);
    cyc("mr_s1",   0, 1, 25, 32'hB3,       1, 24, 32'hC1,       0, 0,  0, 0, 0,  0, 0, 0, 1, 25, 32'hB3);
    cyc("mr_s2",   0, 1, 26, 32'hB4,       1, 24, 32'hC1,       0, 0,  0, 0, 0,  0, 0, 0, 1, 26, 32'hB4);
    cyc("mr_s3",   0, 1, 26, 32'hB4,       1, 24, 32'hC1,       0, 0,  0, 0, 0,  1, 1, 0, 1, 24, 32'hC1);
    cyc("mr_end",  0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 32'h0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
